// File: rtl/rmii_rx_deframer_if.sv
// Byte-stream bus from the RMII receive deframer to the MAC receive slot logic.
`timescale 1ns/1ps
interface rmii_rx_deframer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [10:0] rx_len;
  logic        rx_crc_ok;
  logic        rx_err;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err
  );

  modport slave (
    input rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err
  );
endinterface

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, packs LSB-first dibits into
// bytes, runs CRC-32 over every emitted byte and reports frame status.
`timescale 1ns/1ps
module rmii_rx_deframer #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic               phy_rmii_clk,
  input  logic               sys_rst_n,
  input  logic               rx_en,
  input  logic               phy_rmii_crs,
  input  logic [1:0]         phy_rmii_rx_data,
  rmii_rx_deframer_if.master rx
);

  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt;
  logic [1:0]  phase;
  logic [7:0]  shreg;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        oversize;

  logic        pre_load, pre_inc, start, shift, emit, ovf, close;
  logic [7:0]  byte_nxt;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Newest dibit lands in the top bits so the first-received dibit ends up as bits [1:0].
  assign byte_nxt = {phy_rmii_rx_data, shreg[7:2]};

  // State register.
  always_ff @(posedge phy_rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_d  = state_q;
    pre_load = 1'b0;
    pre_inc  = 1'b0;
    start    = 1'b0;
    shift    = 1'b0;
    emit     = 1'b0;
    ovf      = 1'b0;
    close    = 1'b0;
    case (state_q)
      IDLE: begin
        if (phy_rmii_crs) begin
          if (rx_en && phy_rmii_rx_data == 2'b01) begin
            state_d  = PREAMBLE;
            pre_load = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!phy_rmii_crs) begin
          state_d = IDLE;
        end else if (phy_rmii_rx_data == 2'b01) begin
          pre_inc = 1'b1;
        end else if (phy_rmii_rx_data == 2'b11 && pre_cnt >= 4'd3) begin
          state_d = DATA;
          start   = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!phy_rmii_crs) begin
          state_d = IDLE;
          close   = 1'b1;
        end else begin
          shift = 1'b1;
          if (phase == 2'd3) begin
            if (byte_cnt == MAX_L) begin
              ovf     = 1'b1;
              state_d = DROP;
            end else begin
              emit = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!phy_rmii_crs) begin
          state_d = IDLE;
          // Only an oversize frame reaches DROP from DATA, so it still gets closed.
          close   = oversize;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Preamble count, byte assembly, byte count and CRC accumulation.
  always_ff @(posedge phy_rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt  <= '0;
      phase    <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      crc      <= CRC_INIT;
      oversize <= 1'b0;
    end else begin
      if (pre_load)                      pre_cnt <= 4'd1;
      else if (pre_inc && pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
      if (start) begin
        phase    <= '0;
        byte_cnt <= '0;
        crc      <= CRC_INIT;
        oversize <= 1'b0;
      end else begin
        if (shift) begin
          phase <= phase + 2'd1;
          shreg <= byte_nxt;
        end
        if (emit) begin
          byte_cnt <= byte_cnt + 11'd1;
          crc      <= crc_byte(crc, byte_nxt);
        end
        if (ovf)   oversize <= 1'b1;
        if (close) oversize <= 1'b0;
      end
    end
  end

  // Registered byte stream and end-of-frame status.
  always_ff @(posedge phy_rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.rx_sof    <= 1'b0;
      rx.rx_eof    <= 1'b0;
      rx.rx_len    <= '0;
      rx.rx_crc_ok <= 1'b0;
      rx.rx_err    <= 1'b0;
    end else begin
      rx.rx_valid <= emit;
      rx.rx_sof   <= emit && (byte_cnt == 11'd0);
      rx.rx_eof   <= close;
      if (emit) rx.rx_data <= byte_nxt;
      if (close) begin
        rx.rx_len    <= byte_cnt;
        rx.rx_crc_ok <= (crc == CRC_RESIDUE);
        rx.rx_err    <= (byte_cnt < MIN_L) || oversize || (phase != 2'd0);
      end
    end
  end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Bench for rmii_rx_deframer: frame-level reference model plus directed and random frames.
`timescale 1ns/1ps
module tb_rmii_rx_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_en;
  logic       crs;
  logic [1:0] d;

  always #10 clk = ~clk;

  rmii_rx_deframer_if bus ();

  rmii_rx_deframer dut (
    .phy_rmii_clk     (clk),
    .sys_rst_n        (rst_n),
    .rx_en            (rx_en),
    .phy_rmii_crs     (crs),
    .phy_rmii_rx_data (d),
    .rx               (bus)
  );

  typedef struct {
    logic [10:0] len;
    logic        ok;
    logic        err;
  } eof_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          n_valid = 0;
  int          n_eof = 0;
  int          last_valid_cyc = 0;
  logic [10:0] last_len;
  logic        last_ok, last_err;

  logic [7:0]  exp_data_q[$];
  logic        exp_sof_q[$];
  eof_t        exp_eof_q[$];
  int          exp_eof_cyc_q[$];

  logic [7:0]  pl[$];
  logic [1:0]  tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain bit-serial CRC-32 over the first m bytes of pl, with final inversion.
  function automatic logic [31:0] crc32_of(input int m);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ pl[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  // A received frame is good when its last four bytes are the FCS of everything before them.
  function automatic logic fcs_matches(input int m);
    if (m < 4) return 1'b0;
    return crc32_of(m - 4) == {pl[m-1], pl[m-2], pl[m-3], pl[m-4]};
  endfunction

  task automatic build_payload(input int n, input bit with_fcs);
    logic [31:0] c;
    pl = {};
    for (int i = 0; i < (with_fcs ? n - 4 : n); i++) pl.push_back(8'($urandom));
    if (with_fcs) begin
      c = crc32_of(pl.size());
      pl.push_back(c[7:0]);
      pl.push_back(c[15:8]);
      pl.push_back(c[23:16]);
      pl.push_back(c[31:24]);
    end
  endtask

  // Preamble 7x0x55, SFD 0xD5, payload, then optional trailing dibits.
  task automatic build_dibits(input int extra);
    tx_q = {};
    for (int i = 0; i < 28; i++) tx_q.push_back(2'b01);
    tx_q.push_back(2'b01);
    tx_q.push_back(2'b01);
    tx_q.push_back(2'b01);
    tx_q.push_back(2'b11);
    foreach (pl[i]) begin
      tx_q.push_back(pl[i][1:0]);
      tx_q.push_back(pl[i][3:2]);
      tx_q.push_back(pl[i][5:4]);
      tx_q.push_back(pl[i][7:6]);
    end
    for (int i = 0; i < extra; i++) tx_q.push_back(2'($urandom));
  endtask

  // Expected output of a well-formed frame carrying pl plus 'extra' trailing dibits.
  task automatic model_frame(input int extra);
    int   n, m;
    eof_t e;
    n = pl.size();
    m = (n > 1518) ? 1518 : n;
    for (int i = 0; i < m; i++) begin
      exp_data_q.push_back(pl[i]);
      exp_sof_q.push_back(i == 0);
    end
    e.len = 11'(m);
    e.ok  = fcs_matches(m);
    e.err = (m < 64) || (n > 1518) || ((extra % 4) != 0);
    exp_eof_q.push_back(e);
  endtask

  task automatic send(input int en_drop_at, input int rst_at, input bit expect_eof, input int gap);
    foreach (tx_q[i]) begin
      @(negedge clk);
      if (i == en_drop_at) rx_en = 1'b0;
      crs = 1'b1;
      d   = tx_q[i];
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_rx_valid",  bus.rx_valid,  0);
        check("rst_rx_data",   bus.rx_data,   0);
        check("rst_rx_sof",    bus.rx_sof,    0);
        check("rst_rx_eof",    bus.rx_eof,    0);
        check("rst_rx_len",    bus.rx_len,    0);
        check("rst_rx_crc_ok", bus.rx_crc_ok, 0);
        check("rst_rx_err",    bus.rx_err,    0);
      end
      if (i == rst_at + 1) rst_n = 1'b1;
    end
    @(negedge clk);
    crs = 1'b0;
    d   = 2'b00;
    if (expect_eof) exp_eof_cyc_q.push_back(cyc + 1);
    rx_en = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Compare process: every cycle out of reset, outputs against model queues.
  initial begin
    eof_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        if (bus.rx_valid) begin
          n_valid++;
          check("valid_with_eof", bus.rx_eof, 0);
          if (exp_data_q.size() == 0) begin
            check("unexpected_byte", bus.rx_valid, 0);
          end else begin
            check("rx_data", bus.rx_data, exp_data_q.pop_front());
            check("rx_sof",  bus.rx_sof,  exp_sof_q.pop_front());
          end
          if (!bus.rx_sof) check("byte_spacing", cyc - last_valid_cyc, 4);
          last_valid_cyc = cyc;
        end else begin
          check("sof_without_valid", bus.rx_sof, 0);
        end
        if (bus.rx_eof) begin
          n_eof++;
          last_len = bus.rx_len;
          last_ok  = bus.rx_crc_ok;
          last_err = bus.rx_err;
          if (exp_eof_q.size() == 0) begin
            check("unexpected_eof", bus.rx_eof, 0);
          end else begin
            e = exp_eof_q.pop_front();
            check("rx_len",    bus.rx_len,    e.len);
            check("rx_crc_ok", bus.rx_crc_ok, e.ok);
            check("rx_err",    bus.rx_err,    e.err);
            if (exp_eof_cyc_q.size() != 0) check("eof_latency", cyc, exp_eof_cyc_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    int v0, e0, len, extra, gap, idx;
    rst_n = 1'b0;
    rx_en = 1'b1;
    crs   = 1'b0;
    d     = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_rx_valid",  bus.rx_valid,  0);
    check("reset_rx_data",   bus.rx_data,   0);
    check("reset_rx_sof",    bus.rx_sof,    0);
    check("reset_rx_eof",    bus.rx_eof,    0);
    check("reset_rx_len",    bus.rx_len,    0);
    check("reset_rx_crc_ok", bus.rx_crc_ok, 0);
    check("reset_rx_err",    bus.rx_err,    0);

    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    check("crc_model_pin", crc32_of(9), 32'hCBF4_3926);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Valid 64-byte frame.
    v0 = n_valid;
    build_payload(64, 1'b1); model_frame(0); build_dibits(0);
    send(-1, -1, 1'b1, 4);
    check("t1_strobes", n_valid - v0, 64);
    check("t1_len", last_len, 64);
    check("t1_crc_ok", last_ok, 1);
    check("t1_err", last_err, 0);

    // Same length, one payload bit flipped after FCS generation.
    build_payload(64, 1'b1); pl[10] = pl[10] ^ 8'h01; model_frame(0); build_dibits(0);
    send(-1, -1, 1'b1, 4);
    check("t2_len", last_len, 64);
    check("t2_crc_ok", last_ok, 0);
    check("t2_err", last_err, 0);

    // Runt with good FCS.
    build_payload(60, 1'b1); model_frame(0); build_dibits(0);
    send(-1, -1, 1'b1, 4);
    check("t3_len", last_len, 60);
    check("t3_crc_ok", last_ok, 1);
    check("t3_err", last_err, 1);

    // Oversize: 1600 bytes on the wire.
    v0 = n_valid;
    build_payload(1600, 1'b0); model_frame(0); build_dibits(0);
    send(-1, -1, 1'b1, 4);
    check("t4_strobes", n_valid - v0, 1518);
    check("t4_len", last_len, 1518);
    check("t4_err", last_err, 1);

    // Good 64-byte frame plus two trailing dibits.
    v0 = n_valid;
    build_payload(64, 1'b1); model_frame(2); build_dibits(2);
    send(-1, -1, 1'b1, 4);
    check("t5_strobes", n_valid - v0, 64);
    check("t5_len", last_len, 64);
    check("t5_err", last_err, 1);

    // Malformed preamble 01,01,00 followed by junk.
    v0 = n_valid; e0 = n_eof;
    tx_q = {2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 40; i++) tx_q.push_back(2'($urandom));
    send(-1, -1, 1'b0, 4);
    check("t6_strobes", n_valid - v0, 0);
    check("t6_eofs", n_eof - e0, 0);

    // rx_en low at preamble start.
    v0 = n_valid; e0 = n_eof;
    build_payload(64, 1'b1); build_dibits(0);
    rx_en = 1'b0;
    send(-1, -1, 1'b0, 4);
    check("t7_strobes", n_valid - v0, 0);
    check("t7_eofs", n_eof - e0, 0);

    // rx_en dropped at byte 20 does not abort.
    v0 = n_valid;
    build_payload(64, 1'b1); model_frame(0); build_dibits(0);
    send(32 + 20 * 4, -1, 1'b1, 4);
    check("t8_strobes", n_valid - v0, 64);
    check("t8_len", last_len, 64);
    check("t8_err", last_err, 0);

    // Reset pulse at byte 30 with carrier still up; remaining dibits are 00.
    v0 = n_valid; e0 = n_eof;
    build_payload(60, 1'b0);
    for (int i = 30; i < 60; i++) pl[i] = 8'h00;
    for (int i = 0; i < 30; i++) begin
      exp_data_q.push_back(pl[i]);
      exp_sof_q.push_back(i == 0);
    end
    build_dibits(0);
    send(-1, 32 + 30 * 4, 1'b0, 4);
    check("t9_strobes", n_valid - v0, 30);
    check("t9_eofs", n_eof - e0, 0);

    // Valid frame after the reset pulse.
    build_payload(64, 1'b1); model_frame(0); build_dibits(0);
    send(-1, -1, 1'b1, 4);
    check("t10_len", last_len, 64);
    check("t10_crc_ok", last_ok, 1);
    check("t10_err", last_err, 0);

    // Random frames, including back-to-back (gap 0) and corrupted ones.
    for (int f = 0; f < 14; f++) begin
      len   = 40 + int'($urandom_range(160));
      extra = int'($urandom_range(3));
      gap   = int'($urandom_range(3));
      build_payload(len, 1'b1);
      if ($urandom_range(1) == 1) begin
        idx = int'($urandom_range(len - 1));
        pl[idx] = pl[idx] ^ (8'h01 << $urandom_range(7));
      end
      model_frame(extra);
      build_dibits(extra);
      send(-1, -1, 1'b1, gap);
    end

    repeat (10) @(negedge clk);
    check("bytes_outstanding", exp_data_q.size(), 0);
    check("eofs_outstanding", exp_eof_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rmii_rx_deframer.md
# rmii_rx_deframer

RMII receive front-end for the myminimac Ethernet path. It samples CRS_DV and the 2-bit receive data from the PHY, strips the preamble and SFD, and assembles dibits into bytes. It computes the running CRC-32 and presents a byte stream with start, end and status markers to the MAC receive slot logic, which writes the stream into RX memory.

## Interface
- MAX_LEN, 1518, maximum accepted frame length in bytes (DA through FCS)
- MIN_LEN, 64, minimum accepted frame length in bytes
- phy_rmii_clk  in  1  50 MHz RMII reference clock; the only clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- rx_en  in  1  receive enable; sampled only in IDLE
- phy_rmii_crs  in  1  CRS_DV from PHY; high = dibit valid
- phy_rmii_rx_data  in  2  receive dibit, LSB-first within each byte
- rx_data  out  8  assembled byte; valid when rx_valid
- rx_valid  out  1  one-cycle strobe per byte
- rx_sof  out  1  high together with rx_valid on the first byte after SFD
- rx_eof  out  1  one-cycle end-of-frame strobe; never coincident with rx_valid
- rx_len  out  11  byte count of the frame; valid while rx_eof
- rx_crc_ok  out  1  CRC residue correct; valid while rx_eof
- rx_err  out  1  length or alignment error; valid while rx_eof

## Operation
- State machine: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - crs=1, rx_en=1, dibit=01 -> PREAMBLE with preamble count 1.
  - crs=1 with any other condition -> DROP.
  - crs=0 -> stay.
- PREAMBLE:
  - dibit 01 -> count++, saturating at 15.
  - dibit 11 with count>=3 -> DATA. This is the SFD 0xD5.
  - Any other dibit, or 11 with count<3 -> DROP.
  - crs=0 -> IDLE. No rx_eof is produced.
- DATA:
  - Shift register takes byte = {dibit, byte[7:2]}.
  - The 2-bit phase counter wraps 3->0. When phase 3 is sampled, the byte is emitted.
  - Byte counter increments once per emitted byte and saturates at MAX_LEN.
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is updated per emitted byte, including FCS bytes.
  - If a byte would be the (MAX_LEN+1)th, it is not emitted, the oversize flag is set, and the state goes to DROP. The frame is still closed at crs fall.
  - crs=0 -> frame end -> IDLE.
- DROP: ignore all data. crs=0 -> IDLE. rx_eof is produced only if DROP was entered from DATA.
- Frame end reporting, with rx_eof:
  - rx_len = byte count.
  - rx_crc_ok = (CRC register == 0xDEBB20E3 residue, before final inversion).
  - rx_err = (len < MIN_LEN) | oversize | (phase != 0 at crs fall).
  - A partial byte at crs fall is discarded.
- rx_en deasserted mid-frame does not abort the current frame.

## Timing
- All outputs are registered.
- Reset values: rx_data=0, rx_valid=0, rx_sof=0, rx_eof=0, rx_len=0, rx_crc_ok=0, rx_err=0; state IDLE; counters 0; CRC 0xFFFFFFFF.
- Byte latency: if the 4th dibit of a byte is sampled at edge N, rx_valid/rx_data are high for the cycle following edge N.
- Byte spacing: consecutive rx_valid strobes are exactly 4 cycles apart; the downstream stage has no backpressure.
- End latency: if crs=0 is first sampled at edge N, rx_eof is high for the cycle following edge N. rx_len, rx_crc_ok and rx_err are stable in that cycle and hold until the next rx_eof.
- rx_crc_ok includes the last byte: that byte is emitted at least 1 cycle before rx_eof, so its CRC update is complete.
- Back-to-back frames: crs may rise at edge N+1 directly after the end-sample at edge N. IDLE evaluates it in the same cycle rx_eof is high.
- Reset mid-frame: outputs clear immediately (asynchronous). After release with crs still high and non-01 data, the block goes to DROP and emits nothing until crs falls.

## Test plan
- Valid 64-byte frame: preamble 7×0x55, SFD 0xD5, 60 payload bytes, correct FCS -> 64 rx_valid strobes 4 cycles apart; rx_sof on the first; then rx_eof with rx_len=64, rx_crc_ok=1, rx_err=0.
- Same frame with payload byte 10 XORed with 0x01 -> 64 strobes; rx_eof with rx_crc_ok=0, rx_err=0, rx_len=64.
- 60-byte frame with correct FCS -> rx_len=60, rx_crc_ok=1, rx_err=1. A 1600-byte frame -> exactly 1518 strobes, rx_eof with rx_len=1518 and rx_err=1.
- 64-byte frame followed by 2 extra dibits before crs falls -> 64 strobes, no 65th; rx_err=1.
- Malformed preamble 01,01,00 -> no rx_valid and no rx_eof. A frame with rx_en=0 at preamble start -> no output. rx_en dropped at byte 20 of a valid frame -> full 64-byte frame, rx_err=0.
- sys_rst_n pulsed low at byte 30 while crs stays high -> all outputs 0 immediately, no rx_eof. A following valid 64-byte frame is received correctly.
